snoop_bus_sequencer: RTL and testbench

SNOOP_BUS_SEQUENCER -- requirements
Module: snoop_bus_sequencer

---
 rtl/snoop_bus_sequencer_pkg.sv | 25 ++
 rtl/snoop_bus_sequencer_priority.sv | 19 +
 rtl/snoop_bus_sequencer.sv | 170 +++++++++++++++++
 tb/tb_snoop_bus_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_sequencer_pkg.sv
// Shared definitions for the snooping bus sequencer: bus command codes,
// sequencer state encoding and the CPU-count ceiling.
package snoop_bus_sequencer_pkg;

  localparam int MAX_N_CPU = 8;
  localparam int CPU_W     = $clog2(MAX_N_CPU);

  typedef enum logic [1:0] {
    CMD_FILL    = 2'b00,
    CMD_WBACK   = 2'b01,
    CMD_RD_MISS = 2'b10,
    CMD_WR_MISS = 2'b11
  } bus_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SNOOP,
    EXEC,
    WBACK,
    FILL,
    FINISH
  } state_t;

endpackage

// File: rtl/snoop_bus_sequencer_priority.sv
// Picks the lowest-index snooper (other than the issuer) that wants to
// abort and write back; the result is one-hot, or zero when nobody asks.
module snoop_priority_enc
  import snoop_bus_sequencer_pkg::*;
#(
  parameter int N_CPU = 3
) (
  input  logic [N_CPU-1:0] wb_req,
  input  logic [N_CPU-1:0] issuer,
  output logic [N_CPU-1:0] winner
);

  logic [N_CPU-1:0] cand;

  assign cand = wb_req & ~issuer;
  // Two's-complement trick isolates the lowest set bit.
  assign winner = cand & (~cand + N_CPU'(1));

endmodule

// File: rtl/snoop_bus_sequencer.sv
// Sequences one snooping-bus transaction at a time: miss broadcast, snoop
// window, optional write-back from a peer cache, then a fill from memory.
module snoop_bus_sequencer
  import snoop_bus_sequencer_pkg::*;
#(
  parameter int N_CPU      = 3,
  parameter int TAG_W      = 3,
  parameter int DATA_W     = 3,
  parameter int SNOOP_WAIT = 2
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic                    inst_valid,
  output logic                    inst_ready,
  input  logic [CPU_W-1:0]        inst_cpu,
  input  logic                    inst_wr,
  input  logic [TAG_W-1:0]        inst_tag,
  output logic [N_CPU-1:0]        snoop_en,
  output logic [N_CPU-1:0]        req_en,
  input  logic [N_CPU-1:0]        shared_in,
  input  logic [N_CPU-1:0]        wb_req,
  input  logic [N_CPU*DATA_W-1:0] wb_data,
  output logic                    bus_valid,
  output logic [1:0]              bus_cmd,
  output logic [TAG_W-1:0]        bus_tag,
  output logic [DATA_W-1:0]       bus_data,
  output logic                    shared,
  output logic                    done,
  output logic                    err
);

  localparam int DEPTH = 2 ** TAG_W;

  state_t            state_q, state_d;
  logic              armed_q;
  logic [CPU_W-1:0]  cpu_q;
  logic              wr_q;
  logic [TAG_W-1:0]  tag_q;
  logic [3:0]        cnt_q;
  logic              shared_q;
  logic [N_CPU-1:0]  winner_q;
  logic [DATA_W-1:0] wb_q;
  logic              err_q;
  logic [N_CPU-1:0]  issuer_oh;
  logic [N_CPU-1:0]  win_oh;
  logic [DATA_W-1:0] win_data;
  logic              accept;
  logic              bad_cpu;
  logic              snoop_last;
  logic [DATA_W-1:0] mem [DEPTH];

  assign issuer_oh  = N_CPU'(1) << cpu_q;
  assign accept     = inst_valid && inst_ready;
  assign bad_cpu    = (32'(inst_cpu) >= N_CPU);
  assign snoop_last = (state_q == SNOOP) && (cnt_q == 4'd0);
  assign shared     = shared_q;
  assign err        = err_q;

  snoop_priority_enc #(.N_CPU(N_CPU)) u_prio (
    .wb_req (wb_req),
    .issuer (issuer_oh),
    .winner (win_oh)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_CPU; i++) begin
      if (win_oh[i]) win_data = wb_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    inst_ready = 1'b0;
    snoop_en   = '0;
    req_en     = '0;
    bus_valid  = 1'b0;
    bus_cmd    = CMD_FILL;
    bus_tag    = '0;
    bus_data   = '0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        inst_ready = armed_q;
        if (accept && !bad_cpu) state_d = ISSUE;
      end
      ISSUE: begin
        bus_valid = 1'b1;
        bus_cmd   = wr_q ? CMD_WR_MISS : CMD_RD_MISS;
        bus_tag   = tag_q;
        snoop_en  = ~issuer_oh;
        state_d   = SNOOP;
      end
      SNOOP: begin
        snoop_en = ~issuer_oh;
        if (snoop_last) state_d = EXEC;
      end
      EXEC: begin
        req_en  = issuer_oh;
        state_d = (|winner_q) ? WBACK : FILL;
      end
      WBACK: begin
        bus_valid = 1'b1;
        bus_cmd   = CMD_WBACK;
        bus_tag   = tag_q;
        bus_data  = wb_q;
        state_d   = FILL;
      end
      // Memory read is combinational, so a write-back one cycle earlier is already visible.
      FILL: begin
        bus_valid = 1'b1;
        bus_cmd   = CMD_FILL;
        bus_tag   = tag_q;
        bus_data  = mem[tag_q];
        req_en    = issuer_oh;
        state_d   = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      cpu_q    <= '0;
      wr_q     <= 1'b0;
      tag_q    <= '0;
      cnt_q    <= '0;
      shared_q <= 1'b0;
      winner_q <= '0;
      wb_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      err_q   <= 1'b0;
      if (accept) begin
        if (bad_cpu) begin
          err_q <= 1'b1;
        end else begin
          cpu_q <= inst_cpu;
          wr_q  <= inst_wr;
          tag_q <= inst_tag;
        end
      end
      if (state_q == ISSUE) cnt_q <= 4'(SNOOP_WAIT - 1);
      else if (state_q == SNOOP && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      // Snoop responses are sampled only on the final cycle of the window.
      if (snoop_last) begin
        shared_q <= |(shared_in & ~issuer_oh);
        winner_q <= win_oh;
        wb_q     <= win_data;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= DATA_W'(k);
    end else if (state_q == WBACK) begin
      mem[tag_q] <= wb_q;
    end
  end

endmodule

// File: tb/tb_snoop_bus_sequencer.sv
// Self-checking bench: a per-cycle transaction model of the sequencer plus
// directed scenarios with hand-computed expectations.
module tb_snoop_bus_sequencer;

  localparam int NC = 3;
  localparam int SW = 2;
  localparam int DW = 3;
  localparam int TW = 3;

  logic           clock;
  logic           clear_n;
  logic           inst_valid;
  logic           inst_ready;
  logic [2:0]     inst_cpu;
  logic           inst_wr;
  logic [TW-1:0]  inst_tag;
  logic [NC-1:0]  snoop_en;
  logic [NC-1:0]  req_en;
  logic [NC-1:0]  shared_in;
  logic [NC-1:0]  wb_req;
  logic [NC*DW-1:0] wb_data;
  logic           bus_valid;
  logic [1:0]     bus_cmd;
  logic [TW-1:0]  bus_tag;
  logic [DW-1:0]  bus_data;
  logic           shared;
  logic           done;
  logic           err;

  logic        b_valid, b_ready, b_wr;
  logic [2:0]  b_cpu, b_tag;
  logic [7:0]  b_snoop_en, b_req_en, b_shared_in, b_wb_req;
  logic [23:0] b_wb_data;
  logic        b_bus_valid, b_shared, b_done, b_err;
  logic [1:0]  b_bus_cmd;
  logic [2:0]  b_bus_tag, b_bus_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit       rand_mode = 0;
  logic [NC-1:0] dir_shared = '0;
  logic [NC-1:0] dir_wb = '0;

  // behavioural model state
  bit busy = 0;
  int ph = 0;
  int m_cpu = 0;
  bit m_wr = 0;
  int m_tag = 0;
  int m_win = -1;
  int m_wbd = 0;
  bit m_shared = 0;
  bit m_err = 0;
  bit armed = 0;
  int mem_m [8];

  // observations of the DUT for directed checks
  int acc_cyc = 0, done_cyc = 0;
  int obs_issue_cmd = 0, obs_issue_tag = 0;
  int obs_wb_cnt = 0, obs_wb_data = 0;
  int obs_fill_tag = 0, obs_fill_data = 0;
  int valid_beats = 0, err_pulses = 0;

  snoop_bus_sequencer #(.N_CPU(NC), .TAG_W(TW), .DATA_W(DW), .SNOOP_WAIT(SW)) dut (
    .clock(clock), .clear_n(clear_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_cpu(inst_cpu), .inst_wr(inst_wr), .inst_tag(inst_tag),
    .snoop_en(snoop_en), .req_en(req_en), .shared_in(shared_in), .wb_req(wb_req),
    .wb_data(wb_data), .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_tag(bus_tag),
    .bus_data(bus_data), .shared(shared), .done(done), .err(err)
  );

  snoop_bus_sequencer #(.N_CPU(8), .TAG_W(3), .DATA_W(3), .SNOOP_WAIT(15)) u_big (
    .clock(clock), .clear_n(clear_n), .inst_valid(b_valid), .inst_ready(b_ready),
    .inst_cpu(b_cpu), .inst_wr(b_wr), .inst_tag(b_tag),
    .snoop_en(b_snoop_en), .req_en(b_req_en), .shared_in(b_shared_in), .wb_req(b_wb_req),
    .wb_data(b_wb_data), .bus_valid(b_bus_valid), .bus_cmd(b_bus_cmd), .bus_tag(b_bus_tag),
    .bus_data(b_bus_data), .shared(b_shared), .done(b_done), .err(b_err)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // snoop-side inputs: random per cycle, or directed values
  initial begin
    shared_in = '0;
    wb_req = '0;
    forever begin
      @(posedge clock);
      #1;
      if (rand_mode) begin
        shared_in = NC'($urandom);
        wb_req    = NC'($urandom);
      end else begin
        shared_in = dir_shared;
        wb_req    = dir_wb;
      end
    end
  end

  // per-cycle comparison against the transaction model
  always @(negedge clock) begin
    bit e_ready, e_valid, e_done, e_err, e_shared;
    logic [NC-1:0] e_snoop, e_req;
    logic [1:0] e_cmd;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_data;
    int ph_fill;
    e_ready = 0; e_valid = 0; e_done = 0; e_err = 0; e_shared = 0;
    e_snoop = '0; e_req = '0; e_cmd = '0; e_tag = '0; e_data = '0;
    ph_fill = SW + 3 + ((m_win >= 0) ? 1 : 0);
    if (clear_n) begin
      e_shared = m_shared;
      e_err = m_err;
      if (!busy) e_ready = armed;
      else if (ph == 1) begin
        e_valid = 1; e_cmd = m_wr ? 2'b11 : 2'b10; e_tag = TW'(m_tag);
        e_snoop = 3'b111 & ~3'(1 << m_cpu);
      end else if (ph <= SW + 1) e_snoop = 3'b111 & ~3'(1 << m_cpu);
      else if (ph == SW + 2) e_req = 3'(1 << m_cpu);
      else if (m_win >= 0 && ph == SW + 3) begin
        e_valid = 1; e_cmd = 2'b01; e_tag = TW'(m_tag); e_data = DW'(m_wbd);
      end else if (ph == ph_fill) begin
        e_valid = 1; e_cmd = 2'b00; e_tag = TW'(m_tag); e_data = DW'(mem_m[m_tag]);
        e_req = 3'(1 << m_cpu);
      end else e_done = 1;
    end
    check_output("inst_ready", inst_ready, e_ready);
    check_output("err", err, e_err);
    check_output("done", done, e_done);
    check_output("shared", shared, e_shared);
    check_output("snoop_en", snoop_en, e_snoop);
    check_output("req_en", req_en, e_req);
    check_output("bus_valid", bus_valid, e_valid);
    check_output("bus_data", bus_data, e_data);
    if (e_valid) begin
      check_output("bus_cmd", bus_cmd, e_cmd);
      check_output("bus_tag", bus_tag, e_tag);
    end

    if (inst_valid && inst_ready) acc_cyc = cyc;
    if (done) done_cyc = cyc;
    if (err) err_pulses++;
    if (bus_valid) begin
      valid_beats++;
      if (bus_cmd[1]) begin obs_issue_cmd = bus_cmd; obs_issue_tag = bus_tag; end
      else if (bus_cmd == 2'b01) begin obs_wb_cnt++; obs_wb_data = bus_data; end
      else begin obs_fill_tag = bus_tag; obs_fill_data = bus_data; end
    end

    if (!clear_n) begin
      busy = 0; ph = 0; m_err = 0; m_shared = 0; m_win = -1; armed = 0;
      for (int k = 0; k < 8; k++) mem_m[k] = k % (1 << DW);
    end else begin
      m_err = 0;
      if (!busy) begin
        if (e_ready && inst_valid) begin
          if (inst_cpu >= NC) m_err = 1;
          else begin
            busy = 1; ph = 1; m_cpu = inst_cpu; m_wr = inst_wr; m_tag = inst_tag; m_win = -1;
          end
        end
      end else begin
        if (ph == SW + 1) begin
          m_shared = 0;
          m_win = -1;
          for (int i = 0; i < NC; i++) begin
            if (i != m_cpu) begin
              if (shared_in[i]) m_shared = 1;
              if (wb_req[i] && m_win < 0) begin m_win = i; m_wbd = wb_data[i*DW +: DW]; end
            end
          end
        end
        if (m_win >= 0 && ph == SW + 3) mem_m[m_tag] = m_wbd;
        if (ph == ph_fill + 1) busy = 0;
        else ph++;
      end
      armed = 1;
    end
  end

  task automatic apply_stimulus(input int cpu, input bit wr, input int tag);
    int n = 0;
    inst_cpu = 3'(cpu);
    inst_wr = wr;
    inst_tag = TW'(tag);
    inst_valid = 1;
    do begin
      @(negedge clock);
      n++;
    end while (!inst_ready && n < 200);
    check_output("accept_wait", inst_ready, 1);
    @(posedge clock);
    #1;
    inst_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!inst_ready && n < 100);
    check_output("idle_wait", inst_ready, 1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n, k, wb0, beats0, errs0;
    clear_n = 0; inst_valid = 0; inst_cpu = 0; inst_wr = 0; inst_tag = 0; wb_data = '0;
    b_valid = 0; b_cpu = 0; b_wr = 0; b_tag = 0; b_shared_in = 8'h80; b_wb_req = 8'h00; b_wb_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check_output("reset_ready", inst_ready, 0);
    check_output("reset_valid", bus_valid, 0);
    check_output("reset_big_ready", b_ready, 0);
    clear_n = 1;

    // large configuration: CPU3 reads, only CPU7 reports shared
    b_valid = 1; b_cpu = 3; b_tag = 6;
    n = 0;
    while (!b_ready && n < 20) begin @(negedge clock); n++; end
    check_output("big_accept", b_ready, 1);
    @(posedge clock);
    #1;
    b_valid = 0;
    k = 0;
    do begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        check_output("big_snoop_en", b_snoop_en, 8'hF7);
        check_output("big_issue_cmd", b_bus_cmd, 2'b10);
        check_output("big_issue_tag", b_bus_tag, 6);
      end
    end while (!b_done && k < 40);
    check_output("big_latency", k, 19);
    check_output("big_shared", b_shared, 1);
    check_output("big_done_valid", b_bus_valid, 0);
    check_output("big_done_data", b_bus_data, 0);
    check_output("big_done_req", b_req_en, 0);
    check_output("big_err", b_err, 0);
    @(posedge clock);
    #1;

    // CPU0 reads tag 2, nobody shares or writes back
    dir_shared = 3'b000; dir_wb = 3'b000;
    wb0 = obs_wb_cnt;
    apply_stimulus(0, 0, 2);
    wait_idle();
    check_output("rd_latency", done_cyc - acc_cyc, 6);
    check_output("rd_issue_cmd", obs_issue_cmd, 2);
    check_output("rd_issue_tag", obs_issue_tag, 2);
    check_output("rd_fill_tag", obs_fill_tag, 2);
    check_output("rd_fill_data", obs_fill_data, 2);
    check_output("rd_no_wb", obs_wb_cnt - wb0, 0);
    check_output("rd_shared", shared, 0);

    // CPU1 writes tag 0; CPU0 and CPU2 both request write-back (issuer ignored)
    wb_data = {3'd5, 3'd7, 3'd6};
    dir_wb = 3'b111; dir_shared = 3'b010;
    wb0 = obs_wb_cnt;
    apply_stimulus(1, 1, 0);
    wait_idle();
    check_output("wr_latency", done_cyc - acc_cyc, 7);
    check_output("wr_issue_cmd", obs_issue_cmd, 3);
    check_output("wr_wb_count", obs_wb_cnt - wb0, 1);
    check_output("wr_wb_data", obs_wb_data, 6);
    check_output("wr_fill_data", obs_fill_data, 6);
    check_output("wr_shared", shared, 0);
    dir_wb = 3'b000; dir_shared = 3'b000;
    apply_stimulus(2, 0, 0);
    wait_idle();
    check_output("mem0_readback", obs_fill_data, 6);

    // illegal CPU index
    beats0 = valid_beats; errs0 = err_pulses;
    apply_stimulus(5, 0, 3);
    @(negedge clock);
    check_output("bad_err", err, 1);
    check_output("bad_ready", inst_ready, 1);
    repeat (3) @(negedge clock);
    check_output("bad_err_pulses", err_pulses - errs0, 1);
    check_output("bad_no_bus", valid_beats - beats0, 0);
    @(posedge clock);
    #1;

    // reset dropped during write-back
    wb_data = {3'd0, 3'd0, 3'd1};
    dir_wb = 3'b001; dir_shared = 3'b001;
    apply_stimulus(2, 1, 5);
    n = 0;
    do begin @(negedge clock); n++; end while (!(bus_valid && bus_cmd == 2'b01) && n < 40);
    check_output("wb_reached", bus_cmd, 2'b01);
    #2;
    clear_n = 0;
    #1;
    check_output("rst_valid", bus_valid, 0);
    check_output("rst_data", bus_data, 0);
    check_output("rst_shared", shared, 0);
    check_output("rst_snoop", snoop_en, 0);
    check_output("rst_req", req_en, 0);
    check_output("rst_ready", inst_ready, 0);
    check_output("rst_done", done, 0);
    repeat (2) @(posedge clock);
    #1;
    clear_n = 1;
    dir_wb = 3'b000; dir_shared = 3'b000;
    apply_stimulus(0, 0, 5);
    wait_idle();
    check_output("post_rst_latency", done_cyc - acc_cyc, 6);
    check_output("post_rst_mem5", obs_fill_data, 5);

    // randomized traffic
    rand_mode = 1;
    for (int t = 0; t < 80; t++) begin
      wait_idle();
      wb_data = (NC*DW)'($urandom);
      apply_stimulus($urandom_range(0, 4), 1'($urandom), $urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    wait_idle();
    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
